// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-port bundle for mem_ctrl.
// The slave modport is the controller; the master modport is the requester/RAM side.
interface mem_ctrl_if #(
    parameter int RAM_ADDR_WIDTH = 17
);
    logic                      instruction_read_flag;
    logic [31:0]               instruction_read_address_in;
    logic                      instruction_flag;
    logic [31:0]               instruction_read_address;
    logic [31:0]               instruction;
    logic                      data_read_flag;
    logic                      data_write_flag;
    logic [31:0]               data_address;
    logic [1:0]                data_width;
    logic [31:0]               data_write_data;
    logic                      data_flag;
    logic [31:0]               data_read_result;
    logic [7:0]                mem_din;
    logic [7:0]                mem_dout;
    logic [RAM_ADDR_WIDTH-1:0] mem_a;
    logic                      mem_wr;

    modport slave (
        input  instruction_read_flag, instruction_read_address_in,
        input  data_read_flag, data_write_flag, data_address, data_width, data_write_data,
        input  mem_din,
        output instruction_flag, instruction_read_address, instruction,
        output data_flag, data_read_result,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output instruction_read_flag, instruction_read_address_in,
        output data_read_flag, data_write_flag, data_address, data_width, data_write_data,
        output mem_din,
        input  instruction_flag, instruction_read_address, instruction,
        input  data_flag, data_read_result,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbiter serialising fetch and load/store requests onto an 8-bit synchronous RAM.
// Data requests win over fetches; each transfer ends with a one-cycle DONE state.
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                nbytes_q, nbytes_d;
    logic [31:0]               addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               asm_q, asm_d;
    logic                      instr_q, instr_d;
    logic [RAM_ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]                mem_dout_q, mem_dout_d;
    logic                      mem_wr_q, mem_wr_d;
    logic                      iflag_q, iflag_d;
    logic                      dflag_q, dflag_d;
    logic [31:0]               instr_word_q, instr_word_d;
    logic [31:0]               iaddr_q, iaddr_d;
    logic [31:0]               dres_q, dres_d;
    logic [2:0]                nxt_s;
    logic [2:0]                cap_idx_s;
    logic [31:0]               req_addr_s;

    function automatic logic [2:0] width_to_bytes(input logic [1:0] w);
        case (w)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte address wraps modulo the RAM size; upper request bits are dropped.
    function automatic logic [RAM_ADDR_WIDTH-1:0] ram_addr(input logic [31:0] base, input logic [2:0] k);
        return RAM_ADDR_WIDTH'(base + {29'd0, k});
    endfunction

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nbytes_d     = nbytes_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        asm_d        = asm_q;
        instr_d      = instr_q;
        mem_a_d      = {RAM_ADDR_WIDTH{1'b0}};
        mem_dout_d   = 8'h00;
        mem_wr_d     = 1'b0;
        iflag_d      = 1'b0;
        dflag_d      = 1'b0;
        instr_word_d = instr_word_q;
        iaddr_d      = iaddr_q;
        dres_d       = dres_q;
        nxt_s        = cnt_q + 3'd1;
        cap_idx_s    = cnt_q - 3'd1;
        req_addr_s   = (bus.data_write_flag || bus.data_read_flag) ? bus.data_address
                                                                   : bus.instruction_read_address_in;

        case (state_q)
            ST_IDLE: begin
                if (bus.data_write_flag || bus.data_read_flag || bus.instruction_read_flag) begin
                    cnt_d   = 3'd0;
                    addr_d  = req_addr_s;
                    asm_d   = 32'h0000_0000;
                    mem_a_d = ram_addr(req_addr_s, 3'd0);
                    if (bus.data_write_flag) begin
                        state_d    = ST_WRITE;
                        instr_d    = 1'b0;
                        nbytes_d   = width_to_bytes(bus.data_width);
                        wdata_d    = bus.data_write_data;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = bus.data_write_data[7:0];
                    end else if (bus.data_read_flag) begin
                        state_d  = ST_READ;
                        instr_d  = 1'b0;
                        nbytes_d = width_to_bytes(bus.data_width);
                    end else begin
                        state_d  = ST_READ;
                        instr_d  = 1'b1;
                        nbytes_d = 3'd4;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                cnt_d = nxt_s;
                if (nxt_s < nbytes_q) begin
                    mem_a_d = ram_addr(addr_q, nxt_s);
                end else begin
                    mem_a_d = {RAM_ADDR_WIDTH{1'b0}};
                end
                // RAM data lags its address by one cycle, so byte k lands two edges after issue.
                if (cnt_q != 3'd0) begin
                    asm_d = asm_q | ({24'd0, bus.mem_din} << {cap_idx_s, 3'b000});
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_DONE;
                        cnt_d   = 3'd0;
                        if (instr_q) begin
                            iflag_d      = 1'b1;
                            instr_word_d = asm_d;
                            iaddr_d      = addr_q;
                        end else begin
                            dflag_d = 1'b1;
                            dres_d  = asm_d;
                        end
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    asm_d = asm_q;
                end
            end
            ST_WRITE: begin
                cnt_d = nxt_s;
                if (nxt_s < nbytes_q) begin
                    mem_a_d    = ram_addr(addr_q, nxt_s);
                    mem_dout_d = 8'(wdata_q >> {nxt_s, 3'b000});
                    mem_wr_d   = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    cnt_d   = 3'd0;
                    dflag_d = 1'b1;
                    dres_d  = 32'h0000_0000;
                end
            end
            ST_DONE: begin
                // Requests are deliberately not sampled here; the requester drops them on this edge.
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and registered outputs, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            nbytes_q     <= 3'd0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            asm_q        <= 32'h0000_0000;
            instr_q      <= 1'b0;
            mem_a_q      <= {RAM_ADDR_WIDTH{1'b0}};
            mem_dout_q   <= 8'h00;
            mem_wr_q     <= 1'b0;
            iflag_q      <= 1'b0;
            dflag_q      <= 1'b0;
            instr_word_q <= 32'h0000_0000;
            iaddr_q      <= 32'h0000_0000;
            dres_q       <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nbytes_q     <= nbytes_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            asm_q        <= asm_d;
            instr_q      <= instr_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            iflag_q      <= iflag_d;
            dflag_q      <= dflag_d;
            instr_word_q <= instr_word_d;
            iaddr_q      <= iaddr_d;
            dres_q       <= dres_d;
        end
    end

    assign bus.mem_a                    = mem_a_q;
    assign bus.mem_dout                 = mem_dout_q;
    assign bus.mem_wr                   = mem_wr_q;
    assign bus.instruction_flag         = iflag_q;
    assign bus.instruction              = instr_word_q;
    assign bus.instruction_read_address = iaddr_q;
    assign bus.data_flag                = dflag_q;
    assign bus.data_read_result         = dres_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, transaction-timing reference model checked every
// cycle, and directed requests with hand-computed results and latencies.
module tb_mem_ctrl;
    localparam int AW        = 17;
    localparam int RAM_BYTES = 1 << AW;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic mem_init = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   fetch_hits = 0;

    mem_ctrl_if #(.RAM_ADDR_WIDTH(AW)) bus();
    mem_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h00;
            32'h1002: return 8'h50;
            32'h1003: return 8'h00;
            default:  return 8'(a) ^ 8'hA5;
        endcase
    endfunction

    function automatic int w2n(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    // Synchronous byte RAM: read data appears the cycle after its address.
    logic [7:0] ram [RAM_BYTES];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < RAM_BYTES; i++) ram[i] <= init_byte(i);
        end else if (bus.mem_wr) begin
            ram[bus.mem_a] <= bus.mem_dout;
        end
        bus.mem_din <= ram[bus.mem_a];
    end

    // Reference model: a transfer of N bytes accepted at E0 shows addr+t after Et (t<N),
    // completes after E(N+1) for reads or EN for writes, and is back to idle one edge later.
    logic [7:0]  ref_ram [RAM_BYTES];
    logic        m_busy = 1'b0, m_wr = 1'b0, m_instr = 1'b0;
    int          m_t = 0, m_n = 0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
    logic        n_busy, n_wr, n_instr, accept_wr, done;
    int          n_t, n_n;
    logic [31:0] n_addr, n_wdata, m_rd;
    logic [AW-1:0] e_a = '0, ne_a;
    logic        e_wr = 1'b0, e_if = 1'b0, e_df = 1'b0, ne_wr, ne_if, ne_df;
    logic [7:0]  e_dout = 8'h00, ne_dout;
    logic [31:0] e_ins = 32'h0, e_ia = 32'h0, e_dr = 32'h0, ne_ins, ne_ia, ne_dr;

    always_comb begin
        n_busy = m_busy; n_t = m_t + 1; n_addr = m_addr; n_wdata = m_wdata;
        n_n = m_n; n_wr = m_wr; n_instr = m_instr; accept_wr = 1'b0;
        if (!m_busy) begin
            n_t = 0;
            if (bus.data_write_flag) begin
                n_busy = 1'b1; n_wr = 1'b1; n_instr = 1'b0; accept_wr = 1'b1;
                n_addr = bus.data_address; n_n = w2n(bus.data_width); n_wdata = bus.data_write_data;
            end else if (bus.data_read_flag) begin
                n_busy = 1'b1; n_wr = 1'b0; n_instr = 1'b0;
                n_addr = bus.data_address; n_n = w2n(bus.data_width); n_wdata = 32'h0;
            end else if (bus.instruction_read_flag) begin
                n_busy = 1'b1; n_wr = 1'b0; n_instr = 1'b1;
                n_addr = bus.instruction_read_address_in; n_n = 4; n_wdata = 32'h0;
            end
        end else if (m_t + 1 == (m_wr ? m_n + 1 : m_n + 2)) begin
            n_busy = 1'b0; n_t = 0;
        end
        m_rd = 32'h0;
        for (int k = 0; k < 4; k++)
            if (k < n_n) m_rd = m_rd | ({24'h0, ref_ram[AW'(n_addr + 32'(k))]} << (8 * k));
        done    = n_busy && (n_t == (n_wr ? n_n : n_n + 1));
        ne_wr   = n_busy && n_wr && (n_t < n_n);
        ne_a    = (n_busy && n_t < n_n) ? AW'(n_addr + 32'(n_t)) : '0;
        ne_dout = ne_wr ? 8'(n_wdata >> (8 * n_t)) : 8'h00;
        ne_if   = done && n_instr;
        ne_df   = done && !n_instr;
        ne_ins  = e_ins; ne_ia = e_ia; ne_dr = e_dr;
        if (done) begin
            if (n_instr) begin
                ne_ins = m_rd; ne_ia = n_addr;
            end else begin
                ne_dr = n_wr ? 32'h0 : m_rd;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_t <= 0; m_n <= 0; m_wr <= 1'b0; m_instr <= 1'b0;
            m_addr <= 32'h0; m_wdata <= 32'h0;
            e_a <= '0; e_wr <= 1'b0; e_dout <= 8'h00; e_if <= 1'b0; e_df <= 1'b0;
            e_ins <= 32'h0; e_ia <= 32'h0; e_dr <= 32'h0;
        end else begin
            m_busy <= n_busy; m_t <= n_t; m_n <= n_n; m_wr <= n_wr; m_instr <= n_instr;
            m_addr <= n_addr; m_wdata <= n_wdata;
            e_a <= ne_a; e_wr <= ne_wr; e_dout <= ne_dout; e_if <= ne_if; e_df <= ne_df;
            e_ins <= ne_ins; e_ia <= ne_ia; e_dr <= ne_dr;
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < RAM_BYTES; i++) ref_ram[i] <= init_byte(i);
        end else if (accept_wr && !rst) begin
            for (int k = 0; k < 4; k++)
                if (k < n_n) ref_ram[AW'(n_addr + 32'(k))] <= 8'(n_wdata >> (8 * k));
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (bus.mem_a == AW'(32'h1000) && !bus.mem_wr) fetch_hits++;
        n_checks++;
        if ({bus.mem_a, bus.mem_wr, bus.mem_dout, bus.instruction_flag, bus.data_flag,
             bus.instruction, bus.instruction_read_address, bus.data_read_result} !==
            {e_a, e_wr, e_dout, e_if, e_df, e_ins, e_ia, e_dr})
            $display("FAIL cycle@%0t got a=%h wr=%b do=%h if=%b df=%b ins=%h ia=%h dr=%h expected a=%h wr=%b do=%h if=%b df=%b ins=%h ia=%h dr=%h",
                     $time, bus.mem_a, bus.mem_wr, bus.mem_dout, bus.instruction_flag, bus.data_flag,
                     bus.instruction, bus.instruction_read_address, bus.data_read_result,
                     e_a, e_wr, e_dout, e_if, e_df, e_ins, e_ia, e_dr);
        else
            n_pass++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 store+load together. Called at a falling edge;
    // the request is held until one edge after the done pulse. lat = edges from accept to done.
    task automatic do_req(input int kind, input logic [31:0] addr, input logic [1:0] w,
                          input logic [31:0] wd, output int lat);
        lat = -1;
        if (kind == 0) begin
            bus.instruction_read_flag = 1'b1; bus.instruction_read_address_in = addr;
        end else begin
            bus.data_address = addr; bus.data_width = w; bus.data_write_data = wd;
            bus.data_read_flag  = (kind == 1 || kind == 3);
            bus.data_write_flag = (kind == 2 || kind == 3);
        end
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            @(negedge clk);
            if ((kind == 0 && bus.instruction_flag) || (kind != 0 && bus.data_flag)) lat = i - 1;
        end
        @(negedge clk);
        bus.instruction_read_flag = 1'b0; bus.data_read_flag = 1'b0; bus.data_write_flag = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, h0, di, ii, fa;
        bus.instruction_read_flag = 1'b0; bus.instruction_read_address_in = 32'h0;
        bus.data_read_flag = 1'b0; bus.data_write_flag = 1'b0; bus.data_address = 32'h0;
        bus.data_width = 2'd0; bus.data_write_data = 32'h0;
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        chk("reset_outputs", {bus.mem_a, bus.mem_wr, bus.mem_dout, bus.instruction_flag, bus.data_flag},
            32'h0);
        chk("reset_result", bus.data_read_result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch; request held one edge past the done pulse must not refetch.
        h0 = fetch_hits;
        do_req(0, 32'h0000_1000, 2'd2, 32'h0, lat);
        chk("fetch_latency", lat, 5);
        chk("fetch_word", bus.instruction, 32'h0050_0013);
        chk("fetch_addr", bus.instruction_read_address, 32'h0000_1000);
        repeat (4) @(negedge clk);
        chk("fetch_no_duplicate", fetch_hits - h0, 1);

        do_req(2, 32'h0000_0020, 2'd2, 32'hDEAD_BEEF, lat);
        chk("store_word_latency", lat, 4);
        chk("store_result_zero", bus.data_read_result, 32'h0);
        do_req(1, 32'h0000_0020, 2'd2, 32'h0, lat);
        chk("load_word_latency", lat, 5);
        chk("load_word", bus.data_read_result, 32'hDEAD_BEEF);
        do_req(1, 32'h0000_0023, 2'd0, 32'h0, lat);
        chk("load_byte_latency", lat, 2);
        chk("load_byte", bus.data_read_result, 32'h0000_00DE);
        do_req(1, 32'h0000_0022, 2'd1, 32'h0, lat);
        chk("load_half_latency", lat, 3);
        chk("load_half", bus.data_read_result, 32'h0000_DEAD);

        // Fetch and load on the same edge: load first, one idle cycle, then fetch.
        bus.data_read_flag = 1'b1; bus.data_address = 32'h20; bus.data_width = 2'd2;
        bus.instruction_read_flag = 1'b1; bus.instruction_read_address_in = 32'h1000;
        di = -1; ii = -1; fa = -1;
        for (int i = 1; i <= 40 && ii < 0; i++) begin
            @(negedge clk);
            if (bus.data_flag && di < 0) di = i;
            if (di > 0 && i == di + 1) bus.data_read_flag = 1'b0;
            if (di > 0 && fa < 0 && bus.mem_a == AW'(32'h1000)) fa = i;
            if (bus.instruction_flag) ii = i;
        end
        @(negedge clk);
        bus.instruction_read_flag = 1'b0;
        chk("prio_load_done", di, 6);
        chk("prio_fetch_first_addr", fa, 8);
        chk("prio_fetch_done", ii, 13);
        chk("prio_load_data", bus.data_read_result, 32'hDEAD_BEEF);

        // Reset while byte 2 of a fetch is on the bus.
        bus.instruction_read_flag = 1'b1; bus.instruction_read_address_in = 32'h1000;
        repeat (3) @(negedge clk);
        chk("abort_byte2_addr", 32'(bus.mem_a), 32'h1002);
        #1 rst = 1'b1; bus.instruction_read_flag = 1'b0;
        #1 chk("abort_outputs_cleared", {bus.mem_a, bus.mem_wr, bus.instruction_flag}, 32'h0);
        chk("abort_instr_cleared", bus.instruction, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_req(0, 32'h0000_1000, 2'd2, 32'h0, lat);
        chk("refetch_latency", lat, 5);
        chk("refetch_word", bus.instruction, 32'h0050_0013);

        // Address wrap and upper-bit truncation.
        do_req(2, 32'h0003_FFFE, 2'd2, 32'h1122_3344, lat);
        chk("wrap_store_latency", lat, 4);
        do_req(1, 32'h0001_FFFE, 2'd2, 32'h0, lat);
        chk("wrap_load", bus.data_read_result, 32'h1122_3344);
        do_req(1, 32'hFFFE_0000, 2'd3, 32'h0, lat);
        chk("width3_load_latency", lat, 5);
        chk("width3_load", bus.data_read_result, 32'hA6A7_1122);

        // Store and load together: the store (half) wins.
        do_req(3, 32'h0000_0040, 2'd1, 32'hCAFE_5678, lat);
        chk("both_flags_latency", lat, 2);
        chk("both_flags_result", bus.data_read_result, 32'h0);
        do_req(1, 32'h0000_0040, 2'd2, 32'h0, lat);
        chk("half_store_readback", bus.data_read_result, 32'hE6E7_5678);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single arbiter between the instruction-fetch stage, the memory-access stage and an 8-bit synchronous RAM port.
- Serialises 1/2/4-byte requests into byte cycles and assembles little-endian results.
- Returns each completed transfer with a one-cycle done pulse.
- Data requests have priority over instruction fetches. A started transfer always runs to completion.

Parameters:
RAM_ADDR_WIDTH, 17, number of low request-address bits driven onto mem_a; upper bits are ignored

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
instruction_read_flag  input  1  fetch request, level, held until served
instruction_read_address_in  input  32  fetch byte address
instruction_flag  output  1  one-cycle pulse: fetch done
instruction_read_address  output  32  address of the completed fetch (echo)
instruction  output  32  fetched word
data_read_flag  input  1  load request, level
data_write_flag  input  1  store request, level
data_address  input  32  load/store byte address
data_width  input  2  0=byte, 1=half, 2=word, 3=treated as word
data_write_data  input  32  store data, low bytes used
data_flag  output  1  one-cycle pulse: load/store done
data_read_result  output  32  load result, zero-extended
mem_din  input  8  RAM read byte, valid the cycle after its address
mem_dout  output  8  RAM write byte
mem_a  output  RAM_ADDR_WIDTH  RAM byte address
mem_wr  output  1  1=write this cycle

Behaviour:
- Reset (async, immediate): state IDLE, byte counter 0. All outputs 0, including mem_wr, mem_a and mem_dout. Any in-flight transfer is discarded with no done pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE sampling priority, per rising edge:
  - data_write_flag, if set -> WRITE.
  - otherwise data_read_flag -> READ (data).
  - otherwise instruction_read_flag -> READ (instr).
  - At that edge, latch address, byte count N (1/2/4; fetch always 4), write data and requester.
- Let E0 be the accepting edge and Ek the k-th edge after it.
- READ:
  - After Ek, for k=0..N-1: mem_a = addr+k, mem_wr=0.
  - Byte k is captured from mem_din at E(k+2) into result bits [8k+7:8k].
  - After the capture at E(N+1), state -> DONE.
- WRITE:
  - After Ek, for k=0..N-1: mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr=1.
  - At E(N), state -> DONE.
- DONE (exactly one cycle):
  - Assert instruction_flag or data_flag for the latched requester.
  - instruction / instruction_read_address, or data_read_result, hold valid values; stores return data_read_result=0.
  - Next edge -> IDLE.
- No new request is sampled on the edge leaving DONE. The requester updates state on that same edge and drops its request; the first possible re-accept is one edge later. This guarantees no duplicate fetch of a just-filled line.
- Latency, accept edge to done pulse: read N+1 edges (fetch: done high after E5); write N edges.
- Outputs when not in READ/WRITE: mem_wr=0, mem_a=0, mem_dout=0. Done flags are 0 outside DONE. Result registers keep their last value.
- Address arithmetic: addr+k is computed in 32 bits, then truncated to RAM_ADDR_WIDTH; wraps modulo 2^RAM_ADDR_WIDTH. No alignment check.
- Request changes mid-transfer are ignored; all latched values are used.
- A fetch pending during a data transfer waits; it is served after the data transfer's DONE+IDLE cycle, or later if another data request arrives first.
- Both data_read_flag and data_write_flag high: store is performed, load ignored for that acceptance.
- Unpartitioned bytes of data_read_result are 0 for byte/half loads (sign extension is the consumer's job).

Test Plan:
- Fetch 0x00001000, RAM[0x1000..0x1003]=13,00,50,00 -> mem_a 0x1000..0x1003 on consecutive cycles; instruction=0x00500013, instruction_read_address=0x00001000; instruction_flag high exactly one cycle, 5 edges after accept.
- Store word 0xDEADBEEF at 0x20 -> mem_wr high 4 cycles with mem_a 0x20..0x23, mem_dout EF,BE,AD,DE; data_flag 4 edges after accept; readback word = 0xDEADBEEF.
- Byte load from 0x23 after previous store -> data_read_result=0x000000DE; half load from 0x22 -> 0x0000DEAD.
- Fetch and word load raised on the same edge -> load served first (data_flag), then fetch, with exactly one idle cycle between DONE and the fetch's first mem_a.
- Assert rst during byte 2 of a fetch -> mem_wr/mem_a/instruction_flag 0 immediately, no done pulse. After release, a fresh fetch of the same address completes normally.
- Fetch request held high until one edge after instruction_flag -> only one 4-byte RAM read sequence occurs (no duplicate fetch).
